// File: rtl/otp_pkg.sv
// Shared state type and index helpers for the OTP array responder and its bit cells.
package otp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROG  = 2'd1,
        SENSE = 2'd2,
        ERR   = 2'd3
    } otp_state_e;

    // Column c owns two PL lines: even = program enable, odd = read precharge.
    function automatic int pl_prog(input int c);
        return 2 * c;
    endfunction

    function automatic int pl_rd(input int c);
        return 2 * c + 1;
    endfunction

    function automatic int cell_idx(input int r, input int c, input int num_cols);
        return r * num_cols + c;
    endfunction

    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/otp_cell.sv
// One OTP bit cell: fuse bit plus saturating consecutive-pulse counter.
// A masked cell keeps counting but its fuse never blows.
module otp_cell
    import otp_pkg::*;
#(
    parameter int PROG_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic prog_sel,
    input  logic mask,
    output logic fuse,
    output logic fuse_next
);

    localparam int CW = cnt_width(PROG_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(PROG_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Any cycle without a pulse on this cell restarts the count.
    always_comb begin
        cnt_next = '0;
        if (prog_sel) begin
            cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        end
        fuse_next = fuse | (prog_sel && (cnt_next == CNT_MAX) && !mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            fuse <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            fuse <= fuse_next;
        end
    end

endmodule

// File: rtl/otp_array_responder.sv
// OTP bit-cell array plus sense path, driven by the OTP controller's PL/BL/WLN/WLP drive.
// Define OTP_FAULT_INJ_EN to add the fault_mask port (masked cells never blow).
module otp_array_responder
    import otp_pkg::*;
#(
    parameter int A           = 2,
    parameter int B           = 2,
    parameter int PROG_CYCLES = 4,
    parameter int READ_LAT    = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [2*B-1:0] PL,
    input  logic [B-1:0]   BL,
    input  logic [A-1:0]   WLN,
    input  logic [A-1:0]   WLP,
    input  logic           read_active,
`ifdef OTP_FAULT_INJ_EN
    input  logic [A*B-1:0] fault_mask,
`endif
    output logic           writing_successful,
    output logic           output_read_circuit,
    output logic           access_err
);

    otp_state_e state, state_next;

    logic [2*B-1:0] pl_prog_exp, pl_rd_exp;
    logic [A*B-1:0] prog_sel, rd_sel, fuse, fuse_next, cell_mask;
    logic           any_drive, legal_prog, legal_read, illegal;
    logic           eff_prog, eff_read, ws_next, rd_bit, out_q;

`ifdef OTP_FAULT_INJ_EN
    assign cell_mask = fault_mask;
`else
    assign cell_mask = '0;
`endif

    // Expected PL pattern for the column picked by BL; only meaningful when BL is one-hot.
    always_comb begin
        pl_prog_exp = '0;
        pl_rd_exp   = '0;
        for (int c = 0; c < B; c++) begin
            pl_prog_exp[pl_prog(c)] = BL[c];
            pl_rd_exp[pl_rd(c)]     = BL[c];
        end
    end

    assign any_drive  = |{PL, BL, WLN, WLP, read_active};
    assign legal_prog = $onehot(BL) && (PL == pl_prog_exp) && (WLN == '0)
                        && !read_active && (WLP != '0);
    assign legal_read = $onehot(BL) && (PL == pl_rd_exp) && $onehot(WLN)
                        && (WLP == '0) && read_active;
    assign illegal    = any_drive && !legal_prog && !legal_read;
    assign eff_prog   = legal_prog && (state != ERR);
    assign eff_read   = legal_read && (state != ERR);

    for (genvar r = 0; r < A; r++) begin : g_row
        for (genvar c = 0; c < B; c++) begin : g_col
            localparam int IDX = cell_idx(r, c, B);
            assign prog_sel[IDX] = eff_prog & BL[c] & WLP[r];
            assign rd_sel[IDX]   = BL[c] & WLN[r];
            otp_cell #(.PROG_CYCLES(PROG_CYCLES)) u_cell (
                .clk       (clk),
                .reset     (reset),
                .prog_sel  (prog_sel[IDX]),
                .mask      (cell_mask[IDX]),
                .fuse      (fuse[IDX]),
                .fuse_next (fuse_next[IDX])
            );
        end
    end

    // Success includes cells blowing this cycle; reads see the pre-update fuse.
    assign ws_next = eff_prog && ((prog_sel & ~fuse_next) == '0);
    assign rd_bit  = |(fuse & rd_sel);

    always_comb begin
        state_next = state;
        case (state)
            ERR: begin
                if (!any_drive) state_next = IDLE;
            end
            default: begin
                if (!any_drive)      state_next = IDLE;
                else if (legal_prog) state_next = PROG;
                else if (legal_read) state_next = SENSE;
                else                 state_next = ERR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            writing_successful <= 1'b0;
            access_err         <= 1'b0;
        end else begin
            state              <= state_next;
            writing_successful <= ws_next;
            access_err         <= access_err | illegal;
        end
    end

    // Sense pipe: the output stage only reloads when a valid sample reaches it.
    if (READ_LAT == 1) begin : g_lat1
        always_ff @(posedge clk or posedge reset) begin
            if (reset)         out_q <= 1'b0;
            else if (eff_read) out_q <= rd_bit;
        end
    end else begin : g_latn
        logic [READ_LAT-2:0] pipe_v, pipe_d;
        logic [READ_LAT-1:0] chain_v, chain_d;

        assign chain_v = {pipe_v, eff_read};
        assign chain_d = {pipe_d, rd_bit};

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                pipe_v <= '0;
                pipe_d <= '0;
                out_q  <= 1'b0;
            end else begin
                pipe_v <= chain_v[READ_LAT-2:0];
                pipe_d <= chain_d[READ_LAT-2:0];
                if (chain_v[READ_LAT-1]) out_q <= chain_d[READ_LAT-1];
            end
        end
    end

    assign output_read_circuit = out_q;

endmodule
